// File: rtl/timer_share_pkg.sv
// Shared types and helpers for the one-shot delay timer arbiter.
// The optional abort path in the top is enabled by defining TIMER_SHARE_ABORT_EN.
package timer_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Bits needed to hold any value 0..max_val (never less than one).
    function automatic int bits_for(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: search starts one past the last winner
// and wraps modulo NREQ.
module rr_pick
    import timer_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = bits_for(NREQ - 1)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] winner,
    output logic [IW-1:0]   win_idx,
    output logic            valid
);

    always_comb begin
        int cand;
        cand    = 0;
        winner  = '0;
        win_idx = '0;
        valid   = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = int'(last) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                winner[cand] = 1'b1;
                win_idx      = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/timer_share_arbiter.sv
// One down-counting delay timer shared round-robin between NREQ requesters.
// Define TIMER_SHARE_ABORT_EN to add the abort output (owner drops req mid-count).
//
// state | meaning
// IDLE  | timer free; arbitrate among pending req bits
// COUNT | owner holds timer; count decrements each edge
// DONE  | one-cycle done pulse to owner; grant still held
module timer_share_arbiter
    import timer_share_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int MAX  = 15,
    localparam int W    = bits_for(MAX),
    localparam int IW   = bits_for(NREQ - 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] len,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
`ifdef TIMER_SHARE_ABORT_EN
    output logic [NREQ-1:0]   abort,
`endif
    output logic              busy,
    output logic [W-1:0]      count
);

    state_e          state_q, state_d;
    logic [W-1:0]    count_q, count_d;
    logic [IW-1:0]   last_q, last_d;
    logic [NREQ-1:0] owner_oh;
    logic [NREQ-1:0] pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;
    logic [W-1:0]    len_sel;
`ifdef TIMER_SHARE_ABORT_EN
    logic [NREQ-1:0] abort_q, abort_d;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req     (req),
        .last    (last_q),
        .winner  (pick_oh),
        .win_idx (pick_idx),
        .valid   (pick_valid)
    );

    assign len_sel  = len[int'(pick_idx)*W +: W];
    // last_q doubles as the owner index while the timer is held
    assign owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << last_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
            last_q  <= IW'(NREQ - 1);
`ifdef TIMER_SHARE_ABORT_EN
            abort_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            last_q  <= last_d;
`ifdef TIMER_SHARE_ABORT_EN
            abort_q <= abort_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        last_d  = last_q;
`ifdef TIMER_SHARE_ABORT_EN
        abort_d = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = COUNT;
                    last_d  = pick_idx;
                    // a zero length behaves exactly like a length of one
                    count_d = (len_sel == '0) ? W'(1) : len_sel;
                end
            end
            COUNT: begin
`ifdef TIMER_SHARE_ABORT_EN
                if (!req[last_q]) begin
                    state_d = IDLE;
                    count_d = '0;
                    abort_d = owner_oh;
                end else
`endif
                if (count_q <= W'(1)) begin
                    state_d = DONE;
                    count_d = '0;
                end else begin
                    count_d = count_q - W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign grant = busy ? owner_oh : '0;
    assign done  = (state_q == DONE) ? owner_oh : '0;
    assign count = count_q;
`ifdef TIMER_SHARE_ABORT_EN
    assign abort = abort_q;
`endif

endmodule

// File: tb/tb_timer_share_arbiter.sv
// Self-checking bench for timer_share_arbiter: inline per-scenario checks plus
// a done-pulse scoreboard fed at stimulus time.
`timescale 1ns/100ps
module tb_timer_share_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] len = '0;
    logic [3:0]  grant;
    logic [3:0]  done;
`ifdef TIMER_SHARE_ABORT_EN
    logic [3:0]  abort;
`endif
    logic        busy;
    logic [3:0]  count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int idx;
        int due;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [3:0] mon_mask;

    timer_share_arbiter #(.NREQ(4), .MAX(15)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .len     (len),
        .grant   (grant),
        .done    (done),
`ifdef TIMER_SHARE_ABORT_EN
        .abort   (abort),
`endif
        .busy    (busy),
        .count   (count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // done scoreboard: each pushed entry must pulse on exactly its due cycle
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && cyc == exp_q[0].due) begin
                mon_e = exp_q.pop_front();
                mon_mask = 4'b0001 << mon_e.idx;
                total++;
                if (done !== mon_mask) begin
                    bad++;
                    $display("FAIL done_sb cyc=%0d: got %b want %b", cyc, done, mon_mask);
                end
            end else if (done !== 4'b0000) begin
                total++;
                bad++;
                $display("FAIL done_unexpected cyc=%0d: got %b want 0000", cyc, done);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic test_reset;
        #1 reset_n = 1'b0;
        #0.5;
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL rst_grant: got %b want 0000", grant); end
        total++; if (done  !== 4'b0000) begin bad++; $display("FAIL rst_done: got %b want 0000", done); end
        total++; if (count !== 4'd0)    begin bad++; $display("FAIL rst_count: got %0d want 0", count); end
        total++; if (busy  !== 1'b0)    begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        #0.5 reset_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic test_round_robin;
        int c, t;
        logic [3:0] eg;
        @(negedge clk);
        len = {4'd1, 4'd1, 4'd1, 4'd1};
        req = 4'b1111;
        c = cyc;
        for (int k = 0; k < 5; k++) exp_q.push_back('{k % 4, c + 2 + 3 * k});
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            t = cyc - (c + 1);
            eg = (t % 3 != 2) ? (4'b0001 << ((t / 3) % 4)) : 4'b0000;
            total++;
            if (grant !== eg) begin bad++; $display("FAIL rr_grant t=%0d: got %b want %b", t, grant, eg); end
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_single;
        logic [3:0] ec;
        @(negedge clk);
        len[3:0] = 4'd3;
        req = 4'b0001;
        exp_q.push_back('{0, cyc + 4});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ec = 4'(3 - k);
            total++; if (grant !== 4'b0001) begin bad++; $display("FAIL single_grant k=%0d: got %b want 0001", k, grant); end
            total++; if (count !== ec)      begin bad++; $display("FAIL single_count k=%0d: got %0d want %0d", k, count, ec); end
        end
        req = 4'b0000;
        @(negedge clk);
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL single_idle_grant: got %b want 0000", grant); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL single_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_zero_len;
        @(negedge clk);
        len[11:8] = 4'd0;
        req = 4'b0100;
        exp_q.push_back('{2, cyc + 2});
        @(negedge clk);
        total++; if (grant !== 4'b0100) begin bad++; $display("FAIL zero_grant0: got %b want 0100", grant); end
        total++; if (busy !== 1'b1)     begin bad++; $display("FAIL zero_busy0: got %b want 1", busy); end
        @(negedge clk);
        total++; if (grant !== 4'b0100) begin bad++; $display("FAIL zero_grant1: got %b want 0100", grant); end
        req = 4'b0000;
        @(negedge clk);
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL zero_grant2: got %b want 0000", grant); end
    endtask

    task automatic test_drop;
        logic [3:0] ec;
        int c;
        @(negedge clk);
        len[3:0] = 4'd5;
        req = 4'b0001;
        c = cyc;
`ifndef TIMER_SHARE_ABORT_EN
        exp_q.push_back('{0, c + 6});
`endif
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ec = 4'(5 - k);
            total++; if (count !== ec) begin bad++; $display("FAIL drop_count k=%0d: got %0d want %0d", k, count, ec); end
        end
        req = 4'b0000;
`ifdef TIMER_SHARE_ABORT_EN
        @(negedge clk);
        total++; if (abort !== 4'b0001) begin bad++; $display("FAIL drop_abort: got %b want 0001", abort); end
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL drop_grant: got %b want 0000", grant); end
        total++; if (count !== 4'd0)    begin bad++; $display("FAIL drop_count0: got %0d want 0", count); end
        @(negedge clk);
        total++; if (abort !== 4'b0000) begin bad++; $display("FAIL drop_abort_clr: got %b want 0000", abort); end
`else
        @(negedge clk);
        total++; if (count !== 4'd1)    begin bad++; $display("FAIL drop_count1: got %0d want 1", count); end
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL drop_grant_held: got %b want 0001", grant); end
        @(negedge clk);
        total++; if (count !== 4'd0)    begin bad++; $display("FAIL drop_count0: got %0d want 0", count); end
        @(negedge clk);
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL drop_grant_rel: got %b want 0000", grant); end
`endif
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        len[3:0] = 4'd7;
        req = 4'b0001;
        repeat (3) @(negedge clk);
        total++; if (count !== 4'd5) begin bad++; $display("FAIL mid_count5: got %0d want 5", count); end
        #1 reset_n = 1'b0;
        #1;
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL mid_grant: got %b want 0000", grant); end
        total++; if (count !== 4'd0)    begin bad++; $display("FAIL mid_count: got %0d want 0", count); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        reset_n = 1'b1;
        req = 4'b0000;
        repeat (6) @(negedge clk);
        len[7:0] = {4'd2, 4'd2};
        req = 4'b0011;
        exp_q.push_back('{0, cyc + 3});
        @(negedge clk);
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL mid_rearb: got %b want 0001", grant); end
        repeat (2) @(negedge clk);
        req = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_zero_len();
        test_drop();
        test_reset_mid();
        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
